// File: rtl/fft_bram_sched.sv
// Routes fixed-length FFT frames into alternating BRAM halves, with host handshake
// per half, optional frame dropping when both halves are busy, and delayed completion flags.
module fft_bram_sched #(
  parameter int unsigned FRAME_BEATS = 128,
  parameter int unsigned DONE_DELAY  = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [383:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  input  logic         enable,
  input  logic         drop_mode,
  input  logic [1:0]   buf_release,
  output logic [1:0]   buf_full,
  output logic         wr_buf,
  output logic         frame_irq,
  output logic [15:0]  frames_dropped,
  output logic         len_err
);

  localparam int unsigned BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned DW = (DONE_DELAY > 0) ? $clog2(DONE_DELAY + 1) : 1;
  localparam logic [BW-1:0] LastBeat  = BW'(FRAME_BEATS - 1);
  localparam logic [DW-1:0] DelayLoad = DW'(DONE_DELAY);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StPass = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q;
  logic [DW-1:0] delay_q;
  logic          delay_buf_q;
  logic          wr_buf_q;
  logic [1:0]    buf_full_q;
  logic [15:0]   dropped_q;
  logic          len_err_q;
  logic          irq_q;

  logic       hs, last_beat, pass_last, drop_last, fire, fire_buf;
  logic [1:0] busy, set_mask;

  assign hs        = s_axis_tvalid & s_axis_tready;
  assign last_beat = (beat_q == LastBeat);
  assign pass_last = (state_q == StPass) && hs && last_beat;
  assign drop_last = (state_q == StDrop) && hs && last_beat;

  // Assumes FRAME_BEATS >= DONE_DELAY so only one completion can be pending at a time.
  assign fire     = (delay_q == DW'(1)) || (pass_last && (DONE_DELAY == 0));
  assign fire_buf = (delay_q != '0) ? delay_buf_q : wr_buf_q;
  assign set_mask = fire ? (2'b01 << fire_buf) : 2'b00;
  assign busy     = buf_full_q | ((delay_q != '0) ? (2'b01 << delay_buf_q) : 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StWait: begin
        if (!enable)                state_d = StIdle;
        else if (!busy[wr_buf_q])   state_d = StPass;
        else if (drop_mode)         state_d = StDrop;
        else                        state_d = StWait;
      end
      StPass:  if (pass_last) state_d = StIdle;
      StDrop:  if (drop_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    case (state_q)
      StPass: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = last_beat;
      end
      StDrop:  s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      delay_q     <= '0;
      delay_buf_q <= 1'b0;
      wr_buf_q    <= 1'b0;
      buf_full_q  <= 2'b00;
      dropped_q   <= 16'd0;
      len_err_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
        if (s_axis_tlast != last_beat) len_err_q <= 1'b1;
      end
      if (pass_last) begin
        delay_q     <= DelayLoad;
        delay_buf_q <= wr_buf_q;
        wr_buf_q    <= ~wr_buf_q;
      end else if (delay_q != '0) begin
        delay_q <= delay_q - DW'(1);
      end
      // A release coinciding with the set of the same buffer loses.
      buf_full_q <= (buf_full_q & ~buf_release) | set_mask;
      irq_q      <= fire;
      if (drop_last && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign buf_full       = buf_full_q;
  assign wr_buf         = wr_buf_q;
  assign frame_irq      = irq_q;
  assign frames_dropped = dropped_q;
  assign len_err        = len_err_q;

endmodule

// File: tb/tb_fft_bram_sched.sv
// Directed bench for fft_bram_sched: pass-through, buffer wait/release, drop mode,
// length errors, set/release collision and mid-frame reset.
module tb_fft_bram_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [383:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [383:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         enable, drop_mode;
  logic [1:0]   buf_release, buf_full;
  logic         wr_buf, frame_irq, len_err;
  logic [15:0]  frames_dropped;

  int total = 0;
  int bad   = 0;

  // Observations from the last drive_frame call.
  int acc, mv, tl_idx, dmis;

  always #5 clk = ~clk;

  fft_bram_sched dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .enable         (enable),
    .drop_mode      (drop_mode),
    .buf_release    (buf_release),
    .buf_full       (buf_full),
    .wr_buf         (wr_buf),
    .frame_irq      (frame_irq),
    .frames_dropped (frames_dropped),
    .len_err        (len_err)
  );

  // Keeps tvalid high until nbeats handshakes happen; optional downstream backpressure.
  task automatic drive_frame(input int nbeats, input int tlast_at, input bit bp);
    int cyc = 0;
    acc = 0; mv = 0; tl_idx = -1; dmis = 0;
    while (acc < nbeats && cyc < 2000) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (acc == tlast_at);
      s_axis_tdata  = {12{acc[15:0], 16'hA5C3 ^ 16'(cyc)}};
      m_axis_tready = bp ? ((cyc % 3) != 0) : 1'b1;
      #1;
      if (m_axis_tvalid && (m_axis_tdata !== s_axis_tdata)) dmis++;
      if (s_axis_tready) begin
        if (m_axis_tvalid) mv++;
        if (m_axis_tlast) tl_idx = acc;
        acc++;
      end
      cyc++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic pulse_release(input logic [1:0] m);
    @(negedge clk) buf_release = m;
    @(negedge clk) buf_release = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    s_axis_tvalid = 1'b1;
    #1;
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", s_axis_tready); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_mlast got=%b want=0", m_axis_tlast); end
    total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL rst_buf_full got=%b want=00", buf_full); end
    total++; if (wr_buf !== 1'b0) begin bad++; $display("FAIL rst_wr_buf got=%b want=0", wr_buf); end
    total++; if ({frame_irq, len_err} !== 2'b00) begin bad++; $display("FAIL rst_irq_err got=%b want=00", {frame_irq, len_err}); end
    total++; if (frames_dropped !== 16'd0) begin bad++; $display("FAIL rst_dropped got=%0d want=0", frames_dropped); end
    s_axis_tvalid = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int k;
    enable = 1'b1;
    drive_frame(128, 127, 1'b0);
    total++; if (acc !== 128) begin bad++; $display("FAIL single_acc got=%0d want=128", acc); end
    total++; if (mv !== 128) begin bad++; $display("FAIL single_mvalid got=%0d want=128", mv); end
    total++; if (tl_idx !== 127) begin bad++; $display("FAIL single_tlast got=%0d want=127", tl_idx); end
    total++; if (dmis !== 0) begin bad++; $display("FAIL single_data got=%0d want=0", dmis); end
    total++; if (wr_buf !== 1'b1) begin bad++; $display("FAIL single_wr_buf got=%b want=1", wr_buf); end
    total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL single_early_full got=%b want=00", buf_full); end
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_irq) begin k = i; break; end
    end
    total++; if (k !== 12) begin bad++; $display("FAIL single_irq_delay got=%0d want=12", k); end
    total++; if (buf_full !== 2'b01) begin bad++; $display("FAIL single_full got=%b want=01", buf_full); end
    @(negedge clk);
    total++; if (frame_irq !== 1'b0) begin bad++; $display("FAIL single_irq_pulse got=%b want=0", frame_irq); end
  endtask

  task automatic test_wait_release();
    drive_frame(128, 127, 1'b0);
    total++; if (acc !== 128) begin bad++; $display("FAIL wait_f2_acc got=%0d want=128", acc); end
    repeat (14) @(negedge clk);
    total++; if (buf_full !== 2'b11) begin bad++; $display("FAIL wait_full got=%b want=11", buf_full); end
    total++; if (wr_buf !== 1'b0) begin bad++; $display("FAIL wait_wr_buf got=%b want=0", wr_buf); end
    s_axis_tvalid = 1'b1;
    #1;
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL wait_tready got=%b want=0", s_axis_tready); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL wait_mvalid got=%b want=0", m_axis_tvalid); end
    s_axis_tvalid = 1'b0;
    pulse_release(2'b01);
    total++; if (buf_full !== 2'b10) begin bad++; $display("FAIL wait_release got=%b want=10", buf_full); end
    drive_frame(128, 127, 1'b1);
    total++; if (mv !== 128) begin bad++; $display("FAIL wait_resume_mvalid got=%0d want=128", mv); end
    total++; if (tl_idx !== 127) begin bad++; $display("FAIL wait_resume_tlast got=%0d want=127", tl_idx); end
    total++; if (dmis !== 0) begin bad++; $display("FAIL wait_resume_data got=%0d want=0", dmis); end
    repeat (14) @(negedge clk);
    total++; if ({buf_full, wr_buf} !== 3'b111) begin bad++; $display("FAIL wait_after got=%b want=111", {buf_full, wr_buf}); end
  endtask

  task automatic test_drop();
    drop_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      drive_frame(128, 127, 1'b0);
      total++; if (acc !== 128) begin bad++; $display("FAIL drop_acc f%0d got=%0d want=128", f, acc); end
      total++; if (mv !== 0) begin bad++; $display("FAIL drop_mvalid f%0d got=%0d want=0", f, mv); end
    end
    total++; if (frames_dropped !== 16'd3) begin bad++; $display("FAIL drop_count got=%0d want=3", frames_dropped); end
    total++; if ({buf_full, wr_buf} !== 3'b111) begin bad++; $display("FAIL drop_bufs got=%b want=111", {buf_full, wr_buf}); end
    drop_mode = 1'b0;
  endtask

  task automatic test_len_err();
    pulse_release(2'b11);
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL len_pre got=%b want=0", len_err); end
    drive_frame(128, 50, 1'b0);
    total++; if (acc !== 128) begin bad++; $display("FAIL len_acc got=%0d want=128", acc); end
    total++; if (tl_idx !== 127) begin bad++; $display("FAIL len_tlast got=%0d want=127", tl_idx); end
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len_set got=%b want=1", len_err); end
    repeat (14) @(negedge clk);
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len_sticky got=%b want=1", len_err); end
    total++; if ({buf_full, wr_buf} !== 3'b100) begin bad++; $display("FAIL len_bufs got=%b want=100", {buf_full, wr_buf}); end
  endtask

  task automatic test_collision();
    drive_frame(128, 127, 1'b0);
    repeat (11) @(negedge clk);
    buf_release = 2'b01;
    @(negedge clk);
    buf_release = 2'b00;
    total++; if (frame_irq !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b want=1", frame_irq); end
    total++; if (buf_full !== 2'b11) begin bad++; $display("FAIL coll_full got=%b want=11", buf_full); end
  endtask

  task automatic test_reset_mid();
    pulse_release(2'b11);
    drive_frame(60, -1, 1'b0);
    total++; if (acc !== 60) begin bad++; $display("FAIL rmid_acc got=%0d want=60", acc); end
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    #1;
    total++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000) begin bad++; $display("FAIL rmid_hs got=%b want=000", {s_axis_tready, m_axis_tvalid, m_axis_tlast}); end
    total++; if ({buf_full, wr_buf, len_err, frame_irq} !== 5'b0) begin bad++; $display("FAIL rmid_flags got=%b want=00000", {buf_full, wr_buf, len_err, frame_irq}); end
    total++; if (frames_dropped !== 16'd0) begin bad++; $display("FAIL rmid_dropped got=%0d want=0", frames_dropped); end
    s_axis_tvalid = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (buf_full !== 2'b00) begin bad++; $display("FAIL rmid_abandon got=%b want=00", buf_full); end
    drive_frame(128, 127, 1'b0);
    total++; if (mv !== 128) begin bad++; $display("FAIL rmid_clean_mvalid got=%0d want=128", mv); end
    total++; if (tl_idx !== 127) begin bad++; $display("FAIL rmid_clean_tlast got=%0d want=127", tl_idx); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rmid_clean_err got=%b want=0", len_err); end
    repeat (14) @(negedge clk);
    total++; if ({buf_full, wr_buf} !== 3'b011) begin bad++; $display("FAIL rmid_clean_bufs got=%b want=011", {buf_full, wr_buf}); end
  endtask

  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    enable        = 1'b0;
    drop_mode     = 1'b0;
    buf_release   = 2'b00;
    rst           = 1'b1;
    test_reset();
    test_single_frame();
    test_wait_release();
    test_drop();
    test_len_err();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
